stream_mux_arbiter: RTL



---
 rtl/stream_mux_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/stream_mux_arbiter.sv
// stream_mux_arbiter: N-to-1 valid/ready stream mux with internal arbitration
// (round-robin or fixed priority) feeding a single registered output stage.
module stream_mux_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int MODE     = 0,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic [SELW-1:0]           o_channel,
  output logic                      o_valid,
  input  logic                      i_ready
);

  localparam logic [SELW:0]   NCH  = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic [SELW-1:0]  r_ptr;
  logic             r_valid;

  logic             w_load;
  logic             w_found;
  logic             w_fire;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_data;

  // Output register may accept a new beat when empty or being drained.
  assign w_load = ~r_valid | i_ready;
  // Reset level gates the grant so o_ready is zero throughout reset.
  assign w_fire = w_load & w_found & i_reset;

  // Arbitration: first requester from ptr upward (wrapping), or lowest index.
  always_comb begin
    logic [SELW:0]   v_sum;
    logic [SELW-1:0] v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (MODE == 0) begin
        // ptr + i stays below 2*CHANNELS, so one conditional subtract wraps it.
        v_sum = {1'b0, r_ptr} + i[SELW:0];
        if (v_sum >= NCH) v_sum = v_sum - NCH;
        v_idx = v_sum[SELW-1:0];
      end else begin
        v_idx = i[SELW-1:0];
      end
      if (!w_found && i_valid[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = v_idx;
      end
    end
  end

  // Data select for the granted channel.
  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_gnt == k[SELW-1:0]) w_data = i_data[k*WIDTH +: WIDTH];
    end
  end

  // One-hot accept towards the granted channel.
  always_comb begin
    o_ready = '0;
    if (w_fire) o_ready[w_gnt] = 1'b1;
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= w_data;
        r_chan <= w_gnt;
        if (MODE == 0) r_ptr <= (w_gnt == LAST) ? '0 : w_gnt + SELW'(1);
      end
    end
  end

  assign o_data    = r_data;
  assign o_channel = r_chan;
  assign o_valid   = r_valid;

endmodule
